// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: PC-1 at load, then one PC-2 subkey per
// valid/ready handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule #(
  parameter bit PARITY_CHECK = 1'b1,
  parameter bit ALLOW_RELOAD = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        key_load,
  input  logic        decrypt,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Tables use FIPS 1-based, MSB-first bit numbering.
  localparam int PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Bit r set when round r+1 (0-based r) rotates by two instead of one.
  localparam logic [15:0] SHIFT_TWO = 16'h7EFC;

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

  state_t      state_reg, state_next;
  logic [55:0] cd_reg, cd_next;
  logic [3:0]  round_reg, round_next;
  logic        mode_reg, mode_next;
  logic        done_reg, done_next;
  logic        parity_reg, parity_next;

  logic [55:0] pc1_key;
  logic [7:0]  byte_even;
  logic        load_ok;
  logic        shift_two;

  genvar gi;
  generate
    for (gi = 0; gi < 56; gi++) begin : g_pc1
      localparam int SRC = 64 - PC1[gi];
      assign pc1_key[55-gi] = key_in[SRC];
    end
    for (gi = 0; gi < 48; gi++) begin : g_pc2
      localparam int SRC = 56 - PC2[gi];
      assign subkey[47-gi] = cd_reg[SRC];
    end
    for (gi = 0; gi < 8; gi++) begin : g_parity
      assign byte_even[gi] = ~^key_in[8*gi +: 8];
    end
  endgenerate

  assign load_ok = key_load && ((state_reg == IDLE) || ALLOW_RELOAD);

  always_comb begin
    state_next  = state_reg;
    cd_next     = cd_reg;
    round_next  = round_reg;
    mode_next   = mode_reg;
    done_next   = 1'b0;
    parity_next = parity_reg;
    shift_two   = 1'b0;

    if (load_ok) begin
      // A load (also a reload in RUN) takes priority over any pending handshake.
      state_next  = RUN;
      round_next  = 4'd0;
      mode_next   = decrypt;
      parity_next = PARITY_CHECK && (|byte_even);
      if (decrypt) begin
        cd_next = pc1_key;
      end else begin
        cd_next = {rotl(pc1_key[55:28], 1'b0), rotl(pc1_key[27:0], 1'b0)};
      end
    end else if ((state_reg == RUN) && subkey_ready) begin
      if (round_reg == 4'd15) begin
        state_next = IDLE;
        round_next = 4'd0;
        done_next  = 1'b1;
      end else begin
        round_next = round_reg + 4'd1;
        if (mode_reg) begin
          shift_two = SHIFT_TWO[4'd15 - round_reg];
          cd_next   = {rotr(cd_reg[55:28], shift_two), rotr(cd_reg[27:0], shift_two)};
        end else begin
          shift_two = SHIFT_TWO[round_reg + 4'd1];
          cd_next   = {rotl(cd_reg[55:28], shift_two), rotl(cd_reg[27:0], shift_two)};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cd_reg     <= '0;
      round_reg  <= 4'd0;
      mode_reg   <= 1'b0;
      done_reg   <= 1'b0;
      parity_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cd_reg     <= cd_next;
      round_reg  <= round_next;
      mode_reg   <= mode_next;
      done_reg   <= done_next;
      parity_reg <= parity_next;
    end
  end

  assign subkey_valid = (state_reg == RUN);
  assign busy         = (state_reg == RUN);
  assign round_idx    = round_reg;
  assign done         = done_reg;
  assign parity_err   = parity_reg;

endmodule
